// File: rtl/mux_n1_pipe_pkg.sv
// Shared types and helpers for the N:1 pipelined write-back selector.
package mux_pkg;

    typedef enum logic [1:0] {
        VAZIO = 2'b00,
        UM    = 2'b01,
        CHEIO = 2'b10
    } estado_t;

    // Select width never drops below one bit, even for two inputs.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n1_pipe_if.sv
// Upstream/downstream handshake bundle of mux_n1_pipe; master drives, slave is the selector.
interface mux_n1_pipe_if #(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned NUM_ENTRADAS = 4
) ();
    localparam int unsigned SEL_W = mux_pkg::sel_width(NUM_ENTRADAS);

    logic [NUM_ENTRADAS*LARGURA-1:0] entradas;
    logic [SEL_W-1:0]                controle;
    logic                            valido_in;
    logic                            pronto_out;
    logic                            descarta;
    logic [LARGURA-1:0]              saida;
    logic                            valido_out;
    logic                            pronto_in;
    logic                            erro_sel;

    modport master (
        output entradas, controle, valido_in, descarta, pronto_in,
        input  pronto_out, saida, valido_out, erro_sel
    );

    modport slave (
        input  entradas, controle, valido_in, descarta, pronto_in,
        output pronto_out, saida, valido_out, erro_sel
    );
endinterface

// File: rtl/mux_n1.sv
// Combinational N:1 selector; out-of-range selects yield zero and raise fora_faixa.
module mux_n1 import mux_pkg::*; #(
    parameter int unsigned  LARGURA      = 32,
    parameter int unsigned  NUM_ENTRADAS = 4,
    localparam int unsigned SEL_W        = sel_width(NUM_ENTRADAS)
) (
    input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
    input  logic [SEL_W-1:0]                controle,
    output logic [LARGURA-1:0]              valor,
    output logic                            fora_faixa
);

    always_comb begin
        valor      = '0;
        fora_faixa = 1'b1;
        for (int i = 0; i < NUM_ENTRADAS; i++) begin
            if (controle == SEL_W'(i)) begin
                valor      = entradas[i*LARGURA +: LARGURA];
                fora_faixa = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n1_pipe.sv
// N:1 selector with registered valid/ready output and a 2-entry (main + skid) buffer.
module mux_n1_pipe import mux_pkg::*; #(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned NUM_ENTRADAS = 4
) (
    input logic         clock,
    input logic         reset_n,
    mux_n1_pipe_if.slave mux_if
);

    estado_t              estado_q, estado_d;
    logic [LARGURA-1:0]   main_q, main_d, skid_q, skid_d;
    logic                 erro_main_q, erro_main_d, erro_skid_q, erro_skid_d;
    logic [LARGURA-1:0]   valor;
    logic                 fora_faixa;
    logic                 accept, pop;

    mux_n1 #(
        .LARGURA      (LARGURA),
        .NUM_ENTRADAS (NUM_ENTRADAS)
    ) u_sel (
        .entradas   (mux_if.entradas),
        .controle   (mux_if.controle),
        .valor      (valor),
        .fora_faixa (fora_faixa)
    );

    // Handshake outputs come from the state register only: no ready ripple.
    assign mux_if.pronto_out = (estado_q != CHEIO);
    assign mux_if.valido_out = (estado_q != VAZIO);
    assign mux_if.saida      = main_q;
    assign mux_if.erro_sel   = erro_main_q;

    assign accept = mux_if.valido_in & mux_if.pronto_out;
    assign pop    = mux_if.valido_out & mux_if.pronto_in;

    always_comb begin
        estado_d    = estado_q;
        main_d      = main_q;
        skid_d      = skid_q;
        erro_main_d = erro_main_q;
        erro_skid_d = erro_skid_q;
        if (mux_if.descarta) begin
            estado_d    = VAZIO;
            main_d      = '0;
            skid_d      = '0;
            erro_main_d = 1'b0;
            erro_skid_d = 1'b0;
        end else begin
            unique case (estado_q)
                VAZIO: begin
                    if (accept) begin
                        estado_d    = UM;
                        main_d      = valor;
                        erro_main_d = fora_faixa;
                    end
                end
                UM: begin
                    if (accept && !pop) begin
                        estado_d    = CHEIO;
                        skid_d      = valor;
                        erro_skid_d = fora_faixa;
                    end else if (accept && pop) begin
                        main_d      = valor;
                        erro_main_d = fora_faixa;
                    end else if (pop) begin
                        // Draining clears main so saida reads zero while empty.
                        estado_d    = VAZIO;
                        main_d      = '0;
                        erro_main_d = 1'b0;
                    end
                end
                CHEIO: begin
                    if (pop) begin
                        estado_d    = UM;
                        main_d      = skid_q;
                        erro_main_d = erro_skid_q;
                        skid_d      = '0;
                        erro_skid_d = 1'b0;
                    end
                end
                default: begin
                    estado_d    = VAZIO;
                    main_d      = '0;
                    skid_d      = '0;
                    erro_main_d = 1'b0;
                    erro_skid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= VAZIO;
            main_q      <= '0;
            skid_q      <= '0;
            erro_main_q <= 1'b0;
            erro_skid_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            erro_main_q <= erro_main_d;
            erro_skid_q <= erro_skid_d;
        end
    end

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Bench for mux_n1_pipe: directed vector table on N=4/32b, random queue-model runs on N=2,3,5/8b.
module tb_mux_n1_pipe;

    typedef struct {
        logic        vin;
        logic [1:0]  ctl;
        logic        rdy;
        logic        flush;
        logic        vout;
        logic [31:0] dout;
        logic        pout;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } word_t;

    logic clock;
    logic rst_a_n;
    logic rnd_rst_n;
    logic rnd_go;
    bit   done [3];
    int   tests;
    int   fails;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    mux_n1_pipe_if #(.LARGURA(32), .NUM_ENTRADAS(4)) ia ();
    mux_n1_pipe #(.LARGURA(32), .NUM_ENTRADAS(4)) dut_a (
        .clock   (clock),
        .reset_n (rst_a_n),
        .mux_if  (ia)
    );

    // Random runs: model is a FIFO of at most two words with flush.
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int unsigned N  = (g == 0) ? 2 : (g == 1) ? 3 : 5;
        localparam int unsigned SW = mux_pkg::sel_width(N);

        mux_n1_pipe_if #(.LARGURA(8), .NUM_ENTRADAS(N)) rif ();
        mux_n1_pipe #(.LARGURA(8), .NUM_ENTRADAS(N)) dut (
            .clock   (clock),
            .reset_n (rnd_rst_n),
            .mux_if  (rif)
        );

        initial begin : stim
            word_t          q[$];
            word_t          w;
            int             pops;
            int             cyc;
            int unsigned    c;
            logic [8*N-1:0] ent;
            logic           v, r, f, acc, pp;
            pops = 0;
            cyc  = 0;
            done[g] = 1'b0;
            rif.valido_in = 1'b0;
            rif.pronto_in = 1'b0;
            rif.descarta  = 1'b0;
            rif.entradas  = '0;
            rif.controle  = '0;
            wait (rnd_go);
            while (pops < 10000 && cyc < 60000) begin
                @(negedge clock);
                cyc++;
                check($sformatf("rnd N=%0d valido_out", N), 64'(rif.valido_out),
                      64'(q.size() != 0));
                check($sformatf("rnd N=%0d pronto_out", N), 64'(rif.pronto_out),
                      64'(q.size() < 2));
                check($sformatf("rnd N=%0d saida", N), 64'(rif.saida),
                      (q.size() != 0) ? 64'(q[0].d) : 64'd0);
                check($sformatf("rnd N=%0d erro_sel", N), 64'(rif.erro_sel),
                      (q.size() != 0) ? 64'(q[0].e) : 64'd0);
                c = $urandom_range(0, (1 << SW) - 1);
                for (int b = 0; b < int'(N); b++) ent[b*8 +: 8] = 8'($urandom);
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
                f = ($urandom_range(0, 49) == 0);
                if (c < N) begin
                    w.d = 32'((ent >> (c * 8)) & 'hFF);
                    w.e = 1'b0;
                end else begin
                    w.d = 32'd0;
                    w.e = 1'b1;
                end
                rif.entradas  = ent;
                rif.controle  = SW'(c);
                rif.valido_in = v;
                rif.pronto_in = r;
                rif.descarta  = f;
                acc = v && (q.size() < 2);
                pp  = (q.size() != 0) && r;
                if (f) begin
                    q.delete();
                end else begin
                    if (pp) begin
                        void'(q.pop_front());
                        pops++;
                    end
                    if (acc) q.push_back(w);
                end
            end
            check($sformatf("rnd N=%0d transfers reached", N), 64'(pops >= 10000), 64'd1);
            done[g] = 1'b1;
        end
    end

    initial begin : main
        vec_t vecs [20];
        int   wait_cyc;
        vecs = '{
            '{1, 0, 1, 0, 1, 32'h11, 1}, '{1, 1, 1, 0, 1, 32'h22, 1},
            '{1, 2, 1, 0, 1, 32'h33, 1}, '{1, 3, 1, 0, 1, 32'h44, 1},
            '{0, 0, 1, 0, 0, 32'h00, 1},
            '{1, 0, 0, 0, 1, 32'h11, 1}, '{1, 1, 0, 0, 1, 32'h11, 0},
            '{1, 2, 0, 0, 1, 32'h11, 0}, '{1, 2, 1, 0, 1, 32'h22, 1},
            '{1, 2, 1, 0, 1, 32'h33, 1}, '{1, 3, 1, 0, 1, 32'h44, 1},
            '{1, 0, 1, 0, 1, 32'h11, 1}, '{0, 0, 1, 0, 0, 32'h00, 1},
            '{1, 1, 0, 0, 1, 32'h22, 1}, '{1, 2, 0, 0, 1, 32'h22, 0},
            '{1, 3, 0, 1, 0, 32'h00, 1}, '{0, 0, 1, 0, 0, 32'h00, 1},
            '{1, 0, 0, 0, 1, 32'h11, 1}, '{1, 3, 0, 1, 0, 32'h00, 1},
            '{0, 0, 1, 0, 0, 32'h00, 1}
        };
        tests     = 0;
        fails     = 0;
        clock     = 1'b0;
        rst_a_n   = 1'b0;
        rnd_rst_n = 1'b0;
        rnd_go    = 1'b0;
        ia.entradas  = {32'h44, 32'h33, 32'h22, 32'h11};
        ia.controle  = '0;
        ia.valido_in = 1'b0;
        ia.pronto_in = 1'b0;
        ia.descarta  = 1'b0;
        #1;
        check("reset valido_out", 64'(ia.valido_out), 64'd0);
        check("reset pronto_out", 64'(ia.pronto_out), 64'd1);
        check("reset saida", 64'(ia.saida), 64'd0);
        check("reset erro_sel", 64'(ia.erro_sel), 64'd0);
        @(negedge clock);
        @(negedge clock);
        rst_a_n   = 1'b1;
        rnd_rst_n = 1'b1;
        rnd_go    = 1'b1;

        for (int i = 0; i < 20; i++) begin
            ia.valido_in = vecs[i].vin;
            ia.controle  = vecs[i].ctl;
            ia.pronto_in = vecs[i].rdy;
            ia.descarta  = vecs[i].flush;
            @(negedge clock);
            check($sformatf("vec%0d valido_out", i), 64'(ia.valido_out), 64'(vecs[i].vout));
            check($sformatf("vec%0d saida", i), 64'(ia.saida), 64'(vecs[i].dout));
            check($sformatf("vec%0d pronto_out", i), 64'(ia.pronto_out), 64'(vecs[i].pout));
            check($sformatf("vec%0d erro_sel", i), 64'(ia.erro_sel), 64'd0);
        end

        // Asynchronous reset with both buffer entries occupied.
        ia.descarta  = 1'b0;
        ia.pronto_in = 1'b0;
        ia.valido_in = 1'b1;
        ia.controle  = 2'd2;
        @(negedge clock);
        ia.controle  = 2'd3;
        @(negedge clock);
        check("prereset pronto_out", 64'(ia.pronto_out), 64'd0);
        check("prereset saida", 64'(ia.saida), 64'h33);
        #2;
        rst_a_n = 1'b0;
        #1;
        check("async reset valido_out", 64'(ia.valido_out), 64'd0);
        check("async reset saida", 64'(ia.saida), 64'd0);
        check("async reset pronto_out", 64'(ia.pronto_out), 64'd1);
        ia.valido_in = 1'b0;
        ia.pronto_in = 1'b1;
        @(negedge clock);
        rst_a_n = 1'b1;
        @(negedge clock);
        check("post reset valido_out", 64'(ia.valido_out), 64'd0);
        check("post reset saida", 64'(ia.saida), 64'd0);

        wait_cyc = 0;
        while (!(done[0] && done[1] && done[2]) && wait_cyc < 70000) begin
            @(negedge clock);
            wait_cyc++;
        end
        check("random runs completed", 64'(done[0] && done[1] && done[2]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
